// File: rtl/lsu_byte_sequencer_if.sv
// Bundle between the MEM stage, the byte sequencer and the byte-wide data memory.
// The slave view belongs to the sequencer; the master view is the pipeline/memory side.
interface lsu_byte_sequencer_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int XLEN       = 32
);
  logic                  req_valid;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [XLEN-1:0]       req_wdata;

  logic                  stall;
  logic                  rsp_valid;
  logic [XLEN-1:0]       rsp_rdata;
  logic                  rsp_err;

  logic [ADDR_WIDTH-1:0] mem_address;
  logic [7:0]            mem_data_in;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [7:0]            mem_data_out;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
    output stall, rsp_valid, rsp_rdata, rsp_err, mem_address, mem_data_in, mem_rden, mem_wren
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
    input  stall, rsp_valid, rsp_rdata, rsp_err, mem_address, mem_data_in, mem_rden, mem_wren
  );
endinterface

// File: rtl/lsu_byte_sequencer.sv
// Splits RV32 loads/stores into little-endian byte accesses on an async byte memory,
// stalling the MEM stage until the access completes and extending load data.
module lsu_byte_sequencer #(
  parameter int ADDR_WIDTH = 13,
  parameter int XLEN       = 32
) (
  input logic                clk,
  input logic                reset,
  lsu_byte_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] base;
  logic [2:0]            n;
  logic [1:0]            k;
  logic [XLEN-1:0]       wdata;
  logic [XLEN-1:0]       buffer;
  logic                  err;
  logic                  we;
  logic                  uns;
  logic [1:0]            size;

  logic                  req_bad;
  logic [2:0]            req_n;
  logic                  last;
  logic [XLEN-1:0]       load_data;

  always_comb begin
    req_n = 3'd1;
    case (bus.req_size)
      2'b01:   req_n = 3'd2;
      2'b10:   req_n = 3'd4;
      default: req_n = 3'd1;
    endcase
    req_bad = (bus.req_size == 2'b11) ||
              ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
              ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    last = ({1'b0, k} == (n - 3'd1));
  end

  always_comb begin
    load_data = buffer;
    case (size)
      2'b00:   load_data = {{(XLEN-8){~uns & buffer[7]}}, buffer[7:0]};
      2'b01:   load_data = {{(XLEN-16){~uns & buffer[15]}}, buffer[15:0]};
      default: load_data = buffer;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      k      <= 2'd0;
      buffer <= '0;
      err    <= 1'b0;
      base   <= '0;
      n      <= 3'd1;
      wdata  <= '0;
      we     <= 1'b0;
      uns    <= 1'b0;
      size   <= 2'b00;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            base   <= bus.req_addr;
            n      <= req_n;
            wdata  <= bus.req_wdata;
            we     <= bus.req_we;
            uns    <= bus.req_unsigned;
            size   <= bus.req_size;
            err    <= req_bad;
            k      <= 2'd0;
            buffer <= '0;
          end
        end
        ACCESS: begin
          if (!we) begin
            buffer[{k, 3'b000} +: 8] <= bus.mem_data_out;
          end
          k <= k + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // req_valid is deliberately ignored in DONE: the same instruction is still on the bus.
  always_comb begin
    state_next      = state;
    bus.stall       = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.rsp_rdata   = '0;
    bus.rsp_err     = 1'b0;
    bus.mem_address = '0;
    bus.mem_data_in = 8'h00;
    bus.mem_rden    = 1'b0;
    bus.mem_wren    = 1'b0;
    case (state)
      IDLE: begin
        bus.stall = bus.req_valid;
        if (bus.req_valid) begin
          state_next = req_bad ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        bus.stall       = 1'b1;
        bus.mem_address = base + {{(ADDR_WIDTH-2){1'b0}}, k};
        if (we) begin
          bus.mem_wren    = 1'b1;
          bus.mem_data_in = wdata[{k, 3'b000} +: 8];
        end else begin
          bus.mem_rden = 1'b1;
        end
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = err;
        if (!err && !we) begin
          bus.rsp_rdata = load_data;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
